// File: rtl/latch_write_arbiter.sv
// Two-requester round-robin arbiter driving a shared latch bank with a setup/enable/hold write sequence.
// Optional shadow copy of the bank with a read port when LWA_SHADOW_EN is defined.
module latch_write_arbiter #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NENT = 4,
  localparam int unsigned AW  = (NENT > 1) ? $clog2(NENT) : 1
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Req0,
  input  logic            Req1,
  input  logic [AW-1:0]   Addr0,
  input  logic [AW-1:0]   Addr1,
  input  logic [DW-1:0]   Data0,
  input  logic [DW-1:0]   Data1,
  output logic            Gnt0,
  output logic            Gnt1,
  output logic            Done0,
  output logic            Done1,
  output logic [DW-1:0]   Lat_D,
  output logic [NENT-1:0] Lat_En,
  output logic            Busy
`ifdef LWA_SHADOW_EN
  ,
  input  logic [AW-1:0]   Rd_Addr,
  output logic [DW-1:0]   Rd_Q
`endif
);

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic            owner_q;
  logic            ptr_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            start_c;
  logic            win_c;
  logic            addr_ok_c;

  // State, captured request and round-robin pointer
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_c) begin
        owner_q <= win_c;
        addr_q  <= win_c ? Addr1 : Addr0;
        data_q  <= win_c ? Data1 : Data0;
        ptr_q   <= ~win_c;
      end
    end
  end

  // Next state, arbitration and Moore output decode
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    win_c     = 1'b0;
    addr_ok_c = (32'(addr_q) < NENT);
    Busy      = 1'b0;
    Gnt0      = 1'b0;
    Gnt1      = 1'b0;
    Done0     = 1'b0;
    Done1     = 1'b0;
    Lat_D     = '0;
    Lat_En    = '0;

    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          start_c = 1'b1;
          win_c   = (Req0 && Req1) ? ptr_q : Req1;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = ENABLE;
      ENABLE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      Busy  = 1'b1;
      Gnt0  = ~owner_q;
      Gnt1  = owner_q;
      Lat_D = data_q;
    end
    // Enable only in the middle cycle so D is stable one cycle either side
    if (state_q == ENABLE && addr_ok_c) begin
      Lat_En = NENT'(1) << addr_q;
    end
    if (state_q == HOLD) begin
      Done0 = ~owner_q;
      Done1 = owner_q;
    end
  end

`ifdef LWA_SHADOW_EN
  logic [DW-1:0] shadow_q [NENT];

  // Mirror of the latch bank, written as the enable closes
  always_ff @(posedge Clk) begin
    if (Rst) begin
      shadow_q <= '{default: '0};
    end else if (state_q == ENABLE && addr_ok_c) begin
      shadow_q[addr_q] <= data_q;
    end
  end

  always_comb begin
    Rd_Q = '0;
    if (32'(Rd_Addr) < NENT) begin
      Rd_Q = shadow_q[Rd_Addr];
    end
  end
`endif

endmodule
